fsk2_rx_frame_ctrl: RTL and testbench

Sequencer for the 2FSK receive path. After a transmit-start flag it waits a fixed settling delay, then issues one sample strobe per bit period to the slicer. It hunts the sliced bit stream for a sync word and assembles a fixed-length payload into bytes. It reports frame completion or a sync timeout, and sits between the carrier source/flag and downstream byte consumers.

---
 rtl/fsk2_pkg.sv | 18 +
 rtl/fsk2_bit_timer.sv | 45 ++++
 rtl/fsk2_rx_frame_ctrl.sv | 126 ++++++++++++
 tb/tb_fsk2_rx_frame_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fsk2_pkg.sv
// Shared definitions for the 2FSK receive path: state encoding, sync word and
// timing defaults used by both the frame controller and the slicer.
package fsk2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DELAY   = 2'd1,
    ST_HUNT    = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  localparam logic [7:0]  SYNC_WORD_DEF      = 8'hA5;
  localparam int unsigned DELAY_CNT_MAX_DEF  = 20;
  localparam int unsigned SAMPLE_CNT_MAX_DEF = 50;
  localparam int unsigned PAYLOAD_BYTES_DEF  = 4;
  localparam int unsigned HUNT_TIMEOUT_DEF   = 64;

endpackage

// File: rtl/fsk2_bit_timer.sv
// Sample strobe generator: first strobe DELAY_CNT_MAX cycles after start,
// then one strobe every SAMPLE_CNT_MAX cycles while run is high.
module fsk2_bit_timer
  import fsk2_pkg::*;
#(
  parameter int unsigned DELAY_CNT_MAX  = DELAY_CNT_MAX_DEF,
  parameter int unsigned SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic run,
  output logic sample_strobe
);

  localparam logic [7:0] DELAY_LAST  = 8'(DELAY_CNT_MAX);
  localparam logic [7:0] PERIOD_LAST = 8'(SAMPLE_CNT_MAX);

  logic [7:0] cnt;
  logic       settling;
  logic       at_last;

  // settling selects the one-off start delay; afterwards cnt measures bit periods
  assign at_last       = settling ? (cnt == DELAY_LAST) : (cnt == PERIOD_LAST);
  assign sample_strobe = run && !start && at_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= 8'd0;
      settling <= 1'b0;
    end else if (start) begin
      cnt      <= 8'd1;
      settling <= 1'b1;
    end else if (!run) begin
      cnt      <= 8'd0;
      settling <= 1'b0;
    end else if (sample_strobe) begin
      cnt      <= 8'd1;
      settling <= 1'b0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/fsk2_rx_frame_ctrl.sv
// 2FSK receive frame controller: settles after tx_flag, strobes the slicer once
// per bit, hunts for the sync word and assembles the payload into bytes.
module fsk2_rx_frame_ctrl
  import fsk2_pkg::*;
#(
  parameter int unsigned DELAY_CNT_MAX  = DELAY_CNT_MAX_DEF,
  parameter int unsigned SAMPLE_CNT_MAX = SAMPLE_CNT_MAX_DEF,
  parameter logic [7:0]  SYNC_WORD      = SYNC_WORD_DEF,
  parameter int unsigned PAYLOAD_BYTES  = PAYLOAD_BYTES_DEF,
  parameter int unsigned HUNT_TIMEOUT   = HUNT_TIMEOUT_DEF
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       tx_flag,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic       sample_strobe,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_done,
  output logic       sync_err,
  output logic       busy,
  output logic [1:0] fsm_state
);

  localparam logic [9:0] HUNT_LAST  = 10'(HUNT_TIMEOUT);
  localparam logic [7:0] BYTES_LAST = 8'(PAYLOAD_BYTES);

  state_t     state;
  logic [6:0] shift_reg;
  logic [2:0] bit_cnt;
  logic [7:0] byte_cnt;
  logic [9:0] hunt_cnt;
  logic [7:0] window;
  logic [9:0] hunt_next;
  logic [7:0] byte_next;
  logic       timer_run;

  // Only the last 7 bits are stored; the 8-bit window includes the bit arriving now.
  assign window    = {shift_reg, bit_in};
  assign hunt_next = hunt_cnt + 10'd1;
  assign byte_next = byte_cnt + 8'd1;
  assign timer_run = (state != ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

  fsk2_bit_timer #(
    .DELAY_CNT_MAX  (DELAY_CNT_MAX),
    .SAMPLE_CNT_MAX (SAMPLE_CNT_MAX)
  ) u_bit_timer (
    .clk           (sys_clk),
    .rst_n         (sys_rst_n),
    .start         (tx_flag),
    .run           (timer_run),
    .sample_strobe (sample_strobe)
  );

  // byte_valid is a one-cycle pulse with no backpressure: byte_data is valid in
  // that cycle and then holds until the next completed byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      shift_reg  <= 7'd0;
      bit_cnt    <= 3'd0;
      byte_cnt   <= 8'd0;
      hunt_cnt   <= 10'd0;
      byte_data  <= 8'h00;
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
      if (tx_flag) begin
        state     <= ST_DELAY;
        shift_reg <= 7'd0;
        bit_cnt   <= 3'd0;
        byte_cnt  <= 8'd0;
        hunt_cnt  <= 10'd0;
      end else begin
        case (state)
          ST_IDLE: begin
          end
          ST_DELAY: begin
            if (sample_strobe) begin
              state    <= ST_HUNT;
              hunt_cnt <= 10'd0;
            end
          end
          ST_HUNT: begin
            if (bit_valid) begin
              shift_reg <= window[6:0];
              hunt_cnt  <= hunt_next;
              if (hunt_next >= 10'd8 && window == SYNC_WORD) begin
                state    <= ST_PAYLOAD;
                bit_cnt  <= 3'd0;
                byte_cnt <= 8'd0;
              end else if (hunt_next == HUNT_LAST) begin
                sync_err <= 1'b1;
                state    <= ST_IDLE;
              end
            end
          end
          ST_PAYLOAD: begin
            if (bit_valid) begin
              shift_reg <= window[6:0];
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                byte_data  <= window;
                byte_valid <= 1'b1;
                byte_cnt   <= byte_next;
                if (byte_next == BYTES_LAST) begin
                  frame_done <= 1'b1;
                  state      <= ST_IDLE;
                end
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fsk2_rx_frame_ctrl.sv
// Directed bench for fsk2_rx_frame_ctrl: a bit-schedule model predicts every
// output per cycle, with literal checks pinning key cycles and values.
module tb_fsk2_rx_frame_ctrl;
  import fsk2_pkg::*;

  localparam int D    = 20;
  localparam int S    = 50;
  localparam int PB   = 4;
  localparam int HUNT = 64;
  localparam int MAXC = 16384;
  localparam logic [7:0] SYNC = 8'hA5;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       tx_flag;
  logic       bit_in;
  logic       bit_valid;
  logic       sample_strobe;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       frame_done;
  logic       sync_err;
  logic       busy;
  logic [1:0] fsm_state;

  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int frame_t0 = -100000;
  int manual_end = 0;

  bit         plan_bits[$];
  logic [7:0] exp_q[$];
  bit         exp_strobe[MAXC];
  bit         exp_bv[MAXC];
  bit         exp_fd[MAXC];
  bit         exp_se[MAXC];
  bit         exp_busy[MAXC];
  logic [7:0] held;

  fsk2_rx_frame_ctrl #(
    .DELAY_CNT_MAX  (D),
    .SAMPLE_CNT_MAX (S),
    .SYNC_WORD      (SYNC),
    .PAYLOAD_BYTES  (PB),
    .HUNT_TIMEOUT   (HUNT)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .tx_flag       (tx_flag),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .sample_strobe (sample_strobe),
    .byte_data     (byte_data),
    .byte_valid    (byte_valid),
    .frame_done    (frame_done),
    .sync_err      (sync_err),
    .busy          (busy),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  initial begin
    #(MAXC * 10);
    $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- checks ----------------
  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0b, want %0b", name, cyc, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %02h, want %02h", name, cyc, act, exp);
    end
  endtask

  // ---------------- model ----------------
  // Bit m (1-based) is strobed at t0+D+(m-1)*S, answered one cycle later,
  // and its effect shows up on the outputs one cycle after that.
  function automatic int out_cycle(input int t0, input int m);
    return t0 + D + (m - 1) * S + 2;
  endfunction

  task automatic plan_frame(input int t0, input int cut);
    int n_lock;
    int last_bit;
    int endc;
    int c;
    logic [7:0] win;
    logic [7:0] b;
    n_lock = 0;
    for (int m = 8; m <= plan_bits.size() && m <= HUNT; m++) begin
      for (int k = 0; k < 8; k++) win[7-k] = plan_bits[m-8+k];
      if (win == SYNC && n_lock == 0) n_lock = m;
    end
    last_bit = (n_lock != 0) ? n_lock + 8 * PB : HUNT;
    endc = out_cycle(t0, last_bit);
    for (int m = 1; m <= last_bit; m++) begin
      c = t0 + D + (m - 1) * S;
      if (c <= cut && c < MAXC) exp_strobe[c] = 1'b1;
    end
    for (c = t0 + 1; c < endc && c <= cut && c < MAXC; c++) exp_busy[c] = 1'b1;
    if (n_lock != 0) begin
      for (int j = 1; j <= PB; j++) begin
        for (int k = 0; k < 8; k++) b[7-k] = plan_bits[n_lock + 8 * (j - 1) + k];
        c = out_cycle(t0, n_lock + 8 * j);
        if (c <= cut && c < MAXC) begin
          exp_bv[c] = 1'b1;
          exp_q.push_back(b);
          if (j == PB) exp_fd[c] = 1'b1;
        end
      end
    end else if (endc <= cut && endc < MAXC) begin
      exp_se[endc] = 1'b1;
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) plan_bits.push_back(b[k]);
  endtask

  task automatic add_bits(input bit v, input int n);
    for (int k = 0; k < n; k++) plan_bits.push_back(v);
  endtask

  // ---------------- scoreboard / compare ----------------
  initial begin
    held = 8'h00;
    forever begin
      @(negedge sys_clk);
      if (cyc < MAXC) begin
        if (!sys_rst_n) held = 8'h00;
        else if (exp_bv[cyc] && exp_q.size() > 0) held = exp_q.pop_front();
        check1("sample_strobe", sample_strobe, exp_strobe[cyc]);
        check1("byte_valid", byte_valid, exp_bv[cyc]);
        check1("frame_done", frame_done, exp_fd[cyc]);
        check1("sync_err", sync_err, exp_se[cyc]);
        check1("busy", busy, exp_busy[cyc]);
        check8("byte_data", byte_data, held);
      end
    end
  end

  // ---------------- slicer model ----------------
  initial begin
    bit pend;
    bit nb;
    int rel;
    bit_valid = 1'b0;
    bit_in    = 1'b0;
    forever begin
      @(negedge sys_clk);
      pend = (sample_strobe === 1'b1);
      rel  = cyc - frame_t0 - D;
      nb   = (rel >= 0 && rel % S == 0 && rel / S < plan_bits.size()) ? plan_bits[rel / S] : 1'b0;
      @(posedge sys_clk);
      #1;
      if (pend) begin
        bit_valid = 1'b1;
        bit_in    = nb;
      end else if (cyc < manual_end && cyc % 2 == 1) begin
        bit_valid = 1'b1;
        bit_in    = 1'b1;
      end else begin
        bit_valid = 1'b0;
        bit_in    = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) step();
  endtask

  task automatic at_neg(input int c);
    wait_cycle(c);
    @(negedge sys_clk);
  endtask

  task automatic start_frame(input int cut_rel);
    tx_flag  = 1'b1;
    frame_t0 = cyc;
    plan_frame(cyc, (cut_rel < 0) ? MAXC - 1 : cyc + cut_rel);
    step();
    tx_flag = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int t;
    sys_rst_n = 1'b0;
    tx_flag   = 1'b0;

    // reset state
    at_neg(2);
    check1("reset_busy", busy, 1'b0);
    check1("reset_strobe", sample_strobe, 1'b0);
    check8("reset_byte_data", byte_data, 8'h00);
    check1("reset_state_idle", fsm_state == ST_IDLE, 1'b1);
    wait_cycle(4);
    sys_rst_n = 1'b1;

    // nominal frame
    wait_cycle(10);
    plan_bits.delete();
    add_byte(8'hA5); add_byte(8'h12); add_byte(8'h34); add_byte(8'h56); add_byte(8'h78);
    start_frame(-1);
    t = frame_t0;
    at_neg(t + 19);
    check1("nom_no_strobe_19", sample_strobe, 1'b0);
    at_neg(t + 20);
    check1("nom_strobe_20", sample_strobe, 1'b1);
    at_neg(t + 70);
    check1("nom_strobe_70", sample_strobe, 1'b1);
    at_neg(t + 772);
    check1("nom_byte0_valid", byte_valid, 1'b1);
    check8("nom_byte0_data", byte_data, 8'h12);
    at_neg(t + 1971);
    check1("nom_busy_before_end", busy, 1'b1);
    at_neg(t + 1972);
    check1("nom_frame_done", frame_done, 1'b1);
    check8("nom_byte3_data", byte_data, 8'h78);
    check1("nom_busy_fell", busy, 1'b0);

    // sync after 13 noise bits: lock on bit 21
    wait_cycle(t + 1980);
    plan_bits.delete();
    add_bits(1'b1, 8); add_bits(1'b0, 5);
    add_byte(8'hA5); add_byte(8'hC3); add_byte(8'h0F); add_byte(8'hF0); add_byte(8'h99);
    start_frame(-1);
    t = frame_t0;
    at_neg(t + 1422);
    check1("noise_byte0_valid", byte_valid, 1'b1);
    check8("noise_byte0_data", byte_data, 8'hC3);
    at_neg(t + 2622);
    check1("noise_frame_done", frame_done, 1'b1);
    check8("noise_byte3_data", byte_data, 8'h99);

    // hunt timeout
    wait_cycle(t + 2630);
    plan_bits.delete();
    add_bits(1'b0, HUNT);
    start_frame(-1);
    t = frame_t0;
    at_neg(t + 3171);
    check1("timeout_not_early", sync_err, 1'b0);
    at_neg(t + 3172);
    check1("timeout_sync_err", sync_err, 1'b1);
    check1("timeout_idle", fsm_state == ST_IDLE, 1'b1);
    at_neg(t + 3173);
    check1("timeout_single_pulse", sync_err, 1'b0);

    // restart mid-payload after two bytes
    wait_cycle(t + 3180);
    plan_bits.delete();
    add_byte(8'hA5); add_byte(8'h11); add_byte(8'h22); add_byte(8'h33); add_byte(8'h44);
    start_frame(1280);
    t = frame_t0;
    at_neg(t + 1172);
    check8("restart_byte1_data", byte_data, 8'h22);
    wait_cycle(t + 1280);
    plan_bits.delete();
    add_byte(8'hA5); add_byte(8'h55); add_byte(8'h66); add_byte(8'h77); add_byte(8'h88);
    start_frame(-1);
    t = frame_t0;
    at_neg(t + 19);
    check1("restart_no_strobe_19", sample_strobe, 1'b0);
    at_neg(t + 20);
    check1("restart_strobe_20", sample_strobe, 1'b1);
    at_neg(t + 1972);
    check1("restart_frame_done", frame_done, 1'b1);
    check8("restart_last_byte", byte_data, 8'h88);

    // reset mid-hunt
    wait_cycle(t + 1980);
    plan_bits.delete();
    add_bits(1'b0, HUNT);
    start_frame(279);
    t = frame_t0;
    wait_cycle(t + 280);
    sys_rst_n = 1'b0;
    at_neg(t + 280);
    check1("rst_busy", busy, 1'b0);
    check8("rst_byte_data", byte_data, 8'h00);
    check1("rst_state_idle", fsm_state == ST_IDLE, 1'b1);
    wait_cycle(t + 283);
    sys_rst_n = 1'b1;
    manual_end = cyc + 20;
    at_neg(t + 300);
    check1("post_rst_busy", busy, 1'b0);

    // bit_valid in IDLE is ignored, later frame locks cleanly
    wait_cycle(t + 330);
    manual_end = cyc + 20;
    wait_cycle(t + 360);
    plan_bits.delete();
    add_byte(8'hA5); add_byte(8'h9A); add_byte(8'hBC); add_byte(8'hDE); add_byte(8'hF0);
    start_frame(-1);
    t = frame_t0;
    at_neg(t + 772);
    check1("idle_ign_byte0_valid", byte_valid, 1'b1);
    check8("idle_ign_byte0_data", byte_data, 8'h9A);
    at_neg(t + 1972);
    check1("idle_ign_frame_done", frame_done, 1'b1);
    check8("idle_ign_last_byte", byte_data, 8'hF0);
    wait_cycle(t + 1985);

    check1("exp_q_drained", exp_q.size() == 0, 1'b1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
